note_player: RTL and testbench

- Playback stage directly downstream of the note buffer.
- Requests one stored 6-bit note at a time, holds it for a fixed duration, then inserts a silent gap before requesting the next note.
- While a note is held, converts it to a square-wave speaker drive by dividing the system clock.
- Output feeds the board audio pin; status outputs feed the LED/display logic.

---
 rtl/note_player.sv | 171 +++++++++++++++++
 tb/tb_note_player.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// note_player -- playback stage behind the note buffer.
//
// Requests one 6-bit note at a time, sounds it as a square wave for
// NOTE_CYCLES clocks, then stays silent for GAP_CYCLES clocks before it
// requests the next note.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   enable    playback mode; high = run the request/play/gap sequence
//   note_in   note code from the buffer, valid the cycle after note_req
//   note_req  one-cycle strobe asking the buffer for its next note
//   speaker   square-wave audio drive (registered)
//   cur_note  note currently being played, 0 outside PLAY
//   playing   high while in PLAY
//   oct_up    (only with NOTE_PLAYER_OCT_UP_EN) raise the note one octave
//
// Optional feature macro: NOTE_PLAYER_OCT_UP_EN
//
// Note coding: 0 = rest, 1..48 = C3..B6 (n-1 = 12*oct + semi),
// 49..63 are played as rest.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | playback off, all outputs low
// REQ   | note_req high for this single cycle
// LOAD  | buffer presents note_in; latch note and its half period
// PLAY  | note sounding for NOTE_CYCLES clocks
// GAP   | silence for GAP_CYCLES clocks, then REQ (or IDLE)

module note_player #(
  parameter int CLK_HZ      = 100000000,
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [5:0] note_in,
`ifdef NOTE_PLAYER_OCT_UP_EN
  input  logic       oct_up,
`endif
  output logic       note_req,
  output logic       speaker,
  output logic [5:0] cur_note,
  output logic       playing
);

  // Half period (in clocks) of semitone semi in the lowest octave, rounded.
  function automatic logic [23:0] pitch_base(input int semi);
    real f;
    f = 220.0 * (2.0 ** ((semi - 9) / 12.0));
    return 24'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5));
  endfunction

  localparam logic [23:0] PITCH [12] = '{
    pitch_base(0), pitch_base(1), pitch_base(2),  pitch_base(3),
    pitch_base(4), pitch_base(5), pitch_base(6),  pitch_base(7),
    pitch_base(8), pitch_base(9), pitch_base(10), pitch_base(11)
  };

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    LOAD = 3'd2,
    PLAY = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] dur_cnt;
  logic [31:0] gap_cnt;
  logic [23:0] tone_cnt;
  logic [23:0] half_period;
  logic [5:0]  note_q;
  logic        rest_q;
  logic        speaker_q;

  logic [5:0]  idx;
  logic [1:0]  oct;
  logic [3:0]  semi;
  logic [23:0] hp_calc;
  logic        note_valid;

  // Half period for the note being presented on note_in.
  always_comb begin
    idx        = note_in - 6'd1;
    oct        = 2'(idx / 6'd12);
    semi       = 4'(idx % 6'd12);
    note_valid = (note_in != 6'd0) && (note_in <= 6'd48);
    hp_calc    = PITCH[semi] >> oct;
`ifdef NOTE_PLAYER_OCT_UP_EN
    if (oct_up) begin
      hp_calc = hp_calc >> 1;
      if (hp_calc == 24'd0) hp_calc = 24'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    note_req   = 1'b0;
    playing    = 1'b0;
    cur_note   = 6'd0;
    case (state)
      IDLE: if (enable) state_next = REQ;
      REQ: begin
        note_req   = 1'b1;
        state_next = LOAD;
      end
      LOAD: state_next = PLAY;
      PLAY: begin
        playing  = 1'b1;
        cur_note = note_q;
        if (dur_cnt == NOTE_LAST) state_next = GAP;
      end
      GAP: if (gap_cnt == GAP_LAST) state_next = enable ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
    // Dropping enable abandons whatever is in flight.
    if (state != IDLE && !enable) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dur_cnt     <= 32'd0;
      gap_cnt     <= 32'd0;
      tone_cnt    <= 24'd0;
      half_period <= 24'd0;
      note_q      <= 6'd0;
      rest_q      <= 1'b0;
      speaker_q   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          note_q      <= note_in;
          rest_q      <= !note_valid;
          half_period <= hp_calc;
          dur_cnt     <= 32'd0;
          tone_cnt    <= 24'd0;
          speaker_q   <= 1'b0;
        end
        PLAY: begin
          dur_cnt <= dur_cnt + 32'd1;
          gap_cnt <= 32'd0;
          if (tone_cnt == half_period - 24'd1) begin
            tone_cnt <= 24'd0;
            if (!rest_q) speaker_q <= !speaker_q;
          end else begin
            tone_cnt <= tone_cnt + 24'd1;
          end
        end
        GAP: gap_cnt <= gap_cnt + 32'd1;
        default: ;
      endcase
      // Speaker only ever sounds in PLAY; leaving PLAY silences it at once.
      if (state_next != PLAY) speaker_q <= 1'b0;
    end
  end

  assign speaker = speaker_q;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;
  localparam int CLK_HZ = 20000;
  localparam int NC     = 100;
  localparam int GC     = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [5:0] note_in;
  logic       note_req;
  logic       speaker;
  logic [5:0] cur_note;
  logic       playing;
`ifdef NOTE_PLAYER_OCT_UP_EN
  logic       oct_up;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_player #(
    .CLK_HZ(CLK_HZ),
    .NOTE_CYCLES(NC),
    .GAP_CYCLES(GC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .note_in(note_in),
`ifdef NOTE_PLAYER_OCT_UP_EN
    .oct_up(oct_up),
`endif
    .note_req(note_req),
    .speaker(speaker),
    .cur_note(cur_note),
    .playing(playing)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_rest(input int n);
    return (n == 0) || (n > 48);
  endfunction

  // Half period straight from the pitch formula.
  function automatic int model_hp(input int n, input bit up);
    int  idx, o, s, hp;
    real f;
    idx = n - 1;
    o   = idx / 12;
    s   = idx % 12;
    f   = 220.0 * (2.0 ** ((s - 9) / 12.0));
    hp  = $rtoi(CLK_HZ / (2.0 * f) + 0.5);
    hp  = hp >> o;
    if (up) begin
      hp = hp >> 1;
      if (hp == 0) hp = 1;
    end
    return hp;
  endfunction

  // Expected speaker level k cycles after PLAY entry.
  function automatic logic model_spk(input int n, input bit up, input int k);
    int hp;
    if (is_rest(n)) return 1'b0;
    hp = model_hp(n, up);
    return ((k / hp) % 2) == 1;
  endfunction

  function automatic bit pick_up();
`ifdef NOTE_PLAYER_OCT_UP_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Entered on the REQ cycle. Plays note n; if stop_k >= 0 returns while
  // still in PLAY at cycle stop_k, otherwise runs through the gap and
  // ends on the following REQ cycle.
  task automatic play_note(input int n, input bit up, input int stop_k);
    logic exp_spk;
    note_in = 6'($urandom_range(0, 63));
    tick;
    note_in = 6'(n);
`ifdef NOTE_PLAYER_OCT_UP_EN
    oct_up = up;
`endif
    checks++;
    if (note_req !== 1'b0) begin
      errors++;
      $display("FAIL req_width note=%0d got note_req=%b want 0", n, note_req);
    end
    tick;
    note_in = 6'($urandom_range(0, 63));
    for (int k = 0; k < NC; k++) begin
      exp_spk = model_spk(n, up, k);
      checks++;
      if (playing !== 1'b1) begin
        errors++;
        $display("FAIL play_playing note=%0d k=%0d got %b want 1", n, k, playing);
      end
      checks++;
      if (cur_note !== 6'(n)) begin
        errors++;
        $display("FAIL play_cur_note k=%0d got %0d want %0d", k, cur_note, n);
      end
      checks++;
      if (speaker !== exp_spk) begin
        errors++;
        $display("FAIL play_speaker note=%0d up=%0d k=%0d got %b want %b",
                 n, up, k, speaker, exp_spk);
      end
      checks++;
      if (note_req !== 1'b0) begin
        errors++;
        $display("FAIL play_req k=%0d got %b want 0", k, note_req);
      end
      if (k == stop_k) return;
      tick;
    end
    for (int g = 0; g < GC; g++) begin
      checks++;
      if ({speaker, playing, cur_note, note_req} !== 9'd0) begin
        errors++;
        $display("FAIL gap_quiet g=%0d got spk=%b play=%b cur=%0d req=%b want all 0",
                 g, speaker, playing, cur_note, note_req);
      end
      tick;
    end
    checks++;
    if (note_req !== 1'b1) begin
      errors++;
      $display("FAIL req_spacing after note=%0d got note_req=%b want 1 at %0d cycles",
               n, note_req, 2 + NC + GC);
    end
  endtask

  task automatic check_all_low(input string tag);
    checks++;
    if ({speaker, playing, cur_note, note_req} !== 9'd0) begin
      errors++;
      $display("FAIL %s got spk=%b play=%b cur=%0d req=%b want all 0",
               tag, speaker, playing, cur_note, note_req);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    enable  = 1'b0;
    note_in = 6'd0;
`ifdef NOTE_PLAYER_OCT_UP_EN
    oct_up = 1'b0;
`endif
    tick;
    tick;
    check_all_low("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_all_low("idle_disabled");
    end
  endtask

  task automatic test_start;
    enable = 1'b1;
    tick;
    checks++;
    if (note_req !== 1'b1) begin
      errors++;
      $display("FAIL req_after_enable got %b want 1", note_req);
    end
  endtask

  task automatic test_notes;
    int fixed [9] = '{10, 22, 34, 0, 55, 1, 48, 49, 12};
    for (int i = 0; i < 9; i++) play_note(fixed[i], pick_up(), -1);
`ifdef NOTE_PLAYER_OCT_UP_EN
    play_note(10, 1'b1, -1);
    play_note(48, 1'b1, -1);
`endif
    for (int i = 0; i < 6; i++) play_note(int'($urandom_range(0, 63)), pick_up(), -1);
  endtask

  task automatic test_enable_drop;
    play_note(22, 1'b0, 30);
    enable = 1'b0;
    tick;
    check_all_low("drop_to_idle");
    for (int i = 0; i < 5; i++) begin
      tick;
      check_all_low("drop_stays_idle");
    end
    enable = 1'b1;
    tick;
    checks++;
    if (note_req !== 1'b1) begin
      errors++;
      $display("FAIL req_after_reenable got %b want 1", note_req);
    end
    play_note(int'($urandom_range(1, 48)), pick_up(), -1);
  endtask

  task automatic test_reset_mid_play;
    play_note(10, 1'b0, 60);
    rst    = 1'b1;
    enable = 1'b0;
    tick;
    check_all_low("reset_mid_play");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_all_low("post_reset_idle");
    end
    enable = 1'b1;
    tick;
    checks++;
    if (note_req !== 1'b1) begin
      errors++;
      $display("FAIL req_after_reset got %b want 1", note_req);
    end
    play_note(int'($urandom_range(0, 63)), pick_up(), -1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) play_note(int'($urandom_range(1, 48)), pick_up(), -1);
  endtask

  initial begin
    test_reset;
    test_start;
    test_notes;
    test_enable_drop;
    test_reset_mid_play;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
